// File: rtl/inter_link.sv
// inter_link: queued, beat-serialised four-phase board-to-board message link.
// Optional INTER_LINK_REMOTE_RST_EN: all-ones msg_type pulses interboard_rst and flushes the TX queue.
module inter_link #(
  parameter int MSG_W       = 3,
  parameter int NUM_W       = 5,
  parameter int DATA_W      = 6,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_en,
  input  logic [MSG_W-1:0]  ctrl_msg_type,
  input  logic [NUM_W-1:0]  ctrl_number,
  output logic              inter_ready,
  output logic              Request_out,
  output logic              Ack_out,
  output logic [DATA_W-1:0] inter_data_out,
  input  logic              Request_in,
  input  logic              Ack_in,
  input  logic [DATA_W-1:0] inter_data_in,
  output logic              interboard_en,
  output logic [MSG_W-1:0]  interboard_msg_type,
  output logic [NUM_W-1:0]  interboard_number,
  output logic              interboard_rst,
  output logic              link_err
);
  localparam int PAY_W = MSG_W + NUM_W;
  localparam int BEATS = (PAY_W + DATA_W - 1) / DATA_W;
  localparam int EXT_W = BEATS * DATA_W;
  localparam int PAD   = EXT_W - PAY_W;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int BW    = $clog2(BEATS + 1);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, SETUP, REQ, REL} tx_state_t;
  logic              r_req_s1, r_req_s2, r_ack_s1, r_ack_s2;
  logic [PAY_W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wp, r_rp;
  tx_state_t         r_state;
  logic [EXT_W-1:0]  r_tx_sh, r_rx_sh;
  logic [BW-1:0]     r_tx_beat, r_rx_beat;
  logic [TW-1:0]     r_tx_tmr, r_rx_tmr;
  logic [DATA_W-1:0] r_data;
  logic              r_abort, r_tx_err, r_rx_err, r_req_out, r_ack_out, r_rx_done, r_en, r_irst;
  logic [MSG_W-1:0]  r_msg;
  logic [NUM_W-1:0]  r_num;
  logic              w_empty, w_push, w_pop, w_cap, w_remote;
  logic [EXT_W-1:0]  w_head_ext, w_tx_nxt, w_rx_nxt;
  logic [PAY_W-1:0]  w_rx_pay;
  assign w_empty     = r_wp == r_rp;
  assign inter_ready = !((r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]));
  assign w_push      = ctrl_en && inter_ready;
  assign w_pop       = (r_state == IDLE) && !w_empty;
  // Payload is left-justified in the beat frame; the pad bits trail in the last beat.
  assign w_head_ext  = EXT_W'(r_mem[r_rp[AW-1:0]]) << PAD;
  assign w_tx_nxt    = r_tx_sh << DATA_W;
  assign w_rx_nxt    = (r_rx_sh << DATA_W) | EXT_W'(inter_data_in);
  assign w_rx_pay    = r_rx_sh[EXT_W-1 -: PAY_W];
  assign w_cap       = r_req_s2 && !r_ack_out;
`ifdef INTER_LINK_REMOTE_RST_EN
  assign w_remote    = &w_rx_pay[PAY_W-1 -: MSG_W];
`else
  assign w_remote    = 1'b0;
`endif
  assign Request_out         = r_req_out;
  assign Ack_out             = r_ack_out;
  assign inter_data_out      = r_data;
  assign interboard_en       = r_en;
  assign interboard_msg_type = r_msg;
  assign interboard_number   = r_num;
  assign interboard_rst      = r_irst;
  assign link_err            = r_tx_err | r_rx_err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {r_req_s1, r_req_s2, r_ack_s1, r_ack_s2} <= '0;
    end else begin
      {r_req_s2, r_req_s1} <= {r_req_s1, Request_in};
      {r_ack_s2, r_ack_s1} <= {r_ack_s1, Ack_in};
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp <= '0;
      r_rp <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp[AW-1:0]] <= {ctrl_msg_type, ctrl_number};
        r_wp <= r_wp + 1'b1;
      end
      if (r_irst) r_rp <= r_wp;
      else if (w_pop) r_rp <= r_rp + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_tx_sh   <= '0;
      r_data    <= '0;
      r_tx_beat <= '0;
      r_tx_tmr  <= '0;
      r_abort   <= 1'b0;
      r_tx_err  <= 1'b0;
      r_req_out <= 1'b0;
    end else begin
      r_tx_err <= 1'b0;
      case (r_state)
        IDLE: if (!w_empty) begin
          r_tx_sh   <= w_head_ext;
          r_data    <= w_head_ext[EXT_W-1 -: DATA_W];
          r_tx_beat <= '0;
          r_state   <= SETUP;
        end
        SETUP: begin
          r_req_out <= 1'b1;
          r_tx_tmr  <= '0;
          r_state   <= REQ;
        end
        REQ: if (r_ack_s2) begin
          r_req_out <= 1'b0;
          r_tx_tmr  <= '0;
          r_state   <= REL;
        end else if (r_tx_tmr == TW'(TIMEOUT_CYC - 1)) begin
          r_req_out <= 1'b0;
          r_tx_err  <= 1'b1;
          r_abort   <= 1'b1;
          r_state   <= REL;
        end else r_tx_tmr <= r_tx_tmr + 1'b1;
        REL: if (!r_ack_s2) begin
          if (r_abort || r_tx_beat == BW'(BEATS - 1)) begin
            r_abort <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_tx_sh   <= w_tx_nxt;
            r_data    <= w_tx_nxt[EXT_W-1 -: DATA_W];
            r_tx_beat <= r_tx_beat + 1'b1;
            r_state   <= SETUP;
          end
        end else if (!r_abort) begin
          if (r_tx_tmr == TW'(TIMEOUT_CYC - 1)) begin
            r_tx_err <= 1'b1;
            r_abort  <= 1'b1;
          end else r_tx_tmr <= r_tx_tmr + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_sh   <= '0;
      r_rx_beat <= '0;
      r_rx_tmr  <= '0;
      r_ack_out <= 1'b0;
      r_rx_done <= 1'b0;
      r_rx_err  <= 1'b0;
      r_en      <= 1'b0;
      r_irst    <= 1'b0;
      r_msg     <= '0;
      r_num     <= '0;
    end else begin
      r_rx_err  <= 1'b0;
      r_rx_done <= 1'b0;
      r_en      <= 1'b0;
      r_irst    <= 1'b0;
      if (w_cap) begin
        r_rx_sh   <= w_rx_nxt;
        r_ack_out <= 1'b1;
        r_rx_tmr  <= '0;
        r_rx_beat <= (r_rx_beat == BW'(BEATS - 1)) ? '0 : r_rx_beat + 1'b1;
        r_rx_done <= r_rx_beat == BW'(BEATS - 1);
      end else begin
        if (!r_req_s2) r_ack_out <= 1'b0;
        if (r_rx_beat != '0) begin
          if (r_rx_tmr == TW'(TIMEOUT_CYC - 1)) begin
            r_rx_beat <= '0;
            r_rx_tmr  <= '0;
            r_rx_err  <= 1'b1;
          end else r_rx_tmr <= r_rx_tmr + 1'b1;
        end
      end
      if (r_rx_done) begin
        if (w_remote) r_irst <= 1'b1;
        else begin
          r_en  <= 1'b1;
          r_msg <= w_rx_pay[PAY_W-1 -: MSG_W];
          r_num <= w_rx_pay[NUM_W-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_inter_link.sv
// tb_inter_link: directed + randomized checks of inter_link against a message-level reference.
module tb_inter_link;
  localparam int TO = 64;
`ifdef INTER_LINK_REMOTE_RST_EN
  localparam bit REMOTE = 1'b1;
`else
  localparam bit REMOTE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, ctrl_en, inter_ready, Request_out, Ack_out, Request_in, Ack_in;
  logic interboard_en, interboard_rst, link_err;
  logic [2:0] ctrl_msg_type, interboard_msg_type;
  logic [4:0] ctrl_number, interboard_number;
  logic [5:0] inter_data_out, inter_data_in, tb_data;
  logic loop, tb_req, tb_ack;
  int n_chk = 0, n_fail = 0, c;
  logic [7:0] q[$];
  assign Request_in    = loop ? Request_out : tb_req;
  assign Ack_in        = loop ? Ack_out : tb_ack;
  assign inter_data_in = loop ? inter_data_out : tb_data;
  always #5 clk = ~clk;
  inter_link #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ctrl_en(ctrl_en), .ctrl_msg_type(ctrl_msg_type),
    .ctrl_number(ctrl_number), .inter_ready(inter_ready), .Request_out(Request_out),
    .Ack_out(Ack_out), .inter_data_out(inter_data_out), .Request_in(Request_in),
    .Ack_in(Ack_in), .inter_data_in(inter_data_in), .interboard_en(interboard_en),
    .interboard_msg_type(interboard_msg_type), .interboard_number(interboard_number),
    .interboard_rst(interboard_rst), .link_err(link_err));
  function automatic logic [11:0] frame(input logic [2:0] t, input logic [4:0] n);
    return {t, n, 4'b0000};
  endfunction
  function automatic logic sig(input int w);
    return w == 0 ? Request_out : w == 1 ? Ack_out : w == 2 ? link_err : (interboard_en | interboard_rst);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_lvl(input string tag, input int w, input logic lvl, input int lim, output int n);
    n = 0;
    while (sig(w) !== lvl && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(sig(w)), 32'(lvl));
  endtask
  task automatic push(input logic [2:0] t, input logic [4:0] n);
    ctrl_msg_type = t;
    ctrl_number = n;
    ctrl_en = 1'b1;
    @(negedge clk);
    ctrl_en = 1'b0;
  endtask
  task automatic recv(input string tag, input logic [2:0] t, input logic [4:0] n);
    int k;
    wait_lvl({tag, "_strobe"}, 3, 1'b1, 400, k);
    if (REMOTE && t == 3'b111) begin
      chk({tag, "_irst"}, 32'(interboard_rst), 32'd1);
      chk({tag, "_en"}, 32'(interboard_en), 32'd0);
      chk({tag, "_ready"}, 32'(inter_ready), 32'd1);
    end else begin
      chk({tag, "_en"}, 32'(interboard_en), 32'd1);
      chk({tag, "_irst"}, 32'(interboard_rst), 32'd0);
      chk({tag, "_type"}, 32'(interboard_msg_type), 32'(t));
      chk({tag, "_num"}, 32'(interboard_number), 32'(n));
    end
    @(negedge clk);
  endtask
  task automatic send_beat(input string tag, input logic [5:0] d);
    int k;
    tb_data = d;
    tb_req = 1'b1;
    wait_lvl({tag, "_ack1"}, 1, 1'b1, 50, k);
    tb_req = 1'b0;
    wait_lvl({tag, "_ack0"}, 1, 1'b0, 50, k);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [2:0] t;
    logic [4:0] n;
    logic [11:0] e;
    logic [7:0] p;
    int extra;
    rst = 1'b0; ctrl_en = 1'b0; ctrl_msg_type = '0; ctrl_number = '0;
    loop = 1'b0; tb_req = 1'b0; tb_ack = 1'b0; tb_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(Request_out), 0);
    chk("rst_ack", 32'(Ack_out), 0);
    chk("rst_data", 32'(inter_data_out), 0);
    chk("rst_en", 32'(interboard_en), 0);
    chk("rst_type", 32'(interboard_msg_type), 0);
    chk("rst_num", 32'(interboard_number), 0);
    chk("rst_irst", 32'(interboard_rst), 0);
    chk("rst_err", 32'(link_err), 0);
    chk("rst_ready", 32'(inter_ready), 1);
    rst = 1'b1;
    @(negedge clk);
    // Manual peer: observe the two beats of type 5 / number 17.
    push(3'b101, 5'd17);
    e = frame(3'b101, 5'd17);
    wait_lvl("b0_req", 0, 1'b1, 50, c);
    chk("beat0", 32'(inter_data_out), 32'h2c);
    tb_ack = 1'b1;
    wait_lvl("b0_rel", 0, 1'b0, 50, c);
    chk("beat0_hold", 32'(inter_data_out), 32'(e[11:6]));
    tb_ack = 1'b0;
    wait_lvl("b1_req", 0, 1'b1, 50, c);
    chk("beat1", 32'(inter_data_out), 32'h10);
    chk("beat1_model", 32'(inter_data_out), 32'(e[5:0]));
    tb_ack = 1'b1;
    wait_lvl("b1_rel", 0, 1'b0, 50, c);
    tb_ack = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_req", 32'(Request_out), 0);
    chk("idle_ready", 32'(inter_ready), 1);
    // Fill: one in flight plus four queued, then a dropped push.
    for (int i = 0; i < 5; i++) begin
      t = 3'($urandom_range(0, 6));
      n = 5'($urandom);
      q.push_back({t, n});
      push(t, n);
    end
    chk("full_ready", 32'(inter_ready), 0);
    push(3'b010, 5'd9);
    chk("drop_ready", 32'(inter_ready), 0);
    loop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      p = q.pop_front();
      recv("fill_rx", p[7:5], p[4:0]);
    end
    extra = 0;
    repeat (200) begin
      @(negedge clk);
      if (interboard_en) extra++;
    end
    chk("dropped_absent", 32'(extra), 0);
    for (int i = 0; i < 16; i++) begin
      t = (i == 3) ? 3'b111 : 3'($urandom_range(0, 7));
      n = 5'($urandom);
      push(t, n);
      recv("rand_rx", t, n);
    end
    for (int i = 0; i < 3; i++) begin
      t = 3'($urandom_range(0, 6));
      n = 5'($urandom);
      q.push_back({t, n});
      push(t, n);
    end
    for (int i = 0; i < 3; i++) begin
      p = q.pop_front();
      recv("burst_rx", p[7:5], p[4:0]);
    end
    // TX timeout: Ack_in never rises.
    loop = 1'b0;
    repeat (5) @(negedge clk);
    push(3'($urandom_range(0, 6)), 5'($urandom));
    wait_lvl("to_req", 0, 1'b1, 50, c);
    wait_lvl("to_err", 2, 1'b1, TO + 20, c);
    chk("to_window", 32'(c >= TO - 4 && c <= TO + 4), 1);
    chk("to_req_drop", 32'(Request_out), 0);
    repeat (3 * TO) @(negedge clk);
    chk("to_discard_req", 32'(Request_out), 0);
    chk("to_ready", 32'(inter_ready), 1);
    // RX timeout mid-message, then a clean message must still decode.
    t = 3'($urandom_range(0, 6));
    n = 5'($urandom);
    e = frame(t, n);
    send_beat("rxto_b0", e[11:6]);
    wait_lvl("rxto_err", 2, 1'b1, TO + 20, c);
    send_beat("rx_b0", e[11:6]);
    tb_data = e[5:0];
    tb_req = 1'b1;
    recv("rx_after_to", t, n);
    tb_req = 1'b0;
    wait_lvl("rx_ack0", 1, 1'b0, 50, c);
    // Reset while the final beat is acknowledged.
    e = frame(3'b011, 5'd21);
    send_beat("rr_b0", e[11:6]);
    tb_data = e[5:0];
    tb_req = 1'b1;
    wait_lvl("rr_ack1", 1, 1'b1, 50, c);
    rst = 1'b0;
    #1;
    chk("rr_ack", 32'(Ack_out), 0);
    chk("rr_en", 32'(interboard_en), 0);
    chk("rr_ready", 32'(inter_ready), 1);
    tb_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (50) begin
      @(negedge clk);
      if (interboard_en) extra++;
    end
    chk("rr_no_strobe", 32'(extra), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
